// File: rtl/pipe_stage_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_stage_chain                                           |
// | Description : DEPTH-stage valid/ready register chain. It provides bubble |
// |               collapse, flush, per-stage kill, occupancy and a           |
// |               saturating kill counter. PIPE_SKID_EN adds an input skid.  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pipe_stage_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
`ifdef PIPE_SKID_EN
    localparam int c_OCC_W = $clog2(DEPTH + 2)
`else
    localparam int c_OCC_W = $clog2(DEPTH + 1)
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    input  logic               flush,
    input  logic [DEPTH-1:0]   kill_mask,
    output logic [c_OCC_W-1:0] occupancy,
    output logic [CNT_W-1:0]   kill_count
);

    localparam int c_SUM_W = CNT_W + 6;

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CNT_W-1:0] r_kill_count;

    logic [DEPTH-1:0] w_ev;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic [DEPTH-1:0] w_killed;
    logic             w_accept;
    logic             w_s0_v;
    logic [WIDTH-1:0] w_s0_d;
    logic             w_skid_kill;
    logic             w_skid_occ;
    logic [c_SUM_W-1:0] w_kill_pop;
    logic [c_SUM_W-1:0] w_kill_sum;
    logic [c_OCC_W-1:0] w_occ;

    assign w_ev      = r_v & ~kill_mask & {DEPTH{~flush}};
    assign out_valid = w_ev[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];

    // An empty or killed stage always advances, squeezing holes out under stall.
    always_comb begin
        logic w_acc;
        w_adv            = '0;
        w_acc            = out_ready | ~w_ev[DEPTH-1];
        w_adv[DEPTH-1]   = w_acc;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_acc    = ~w_ev[i] | w_acc;
            w_adv[i] = w_acc;
        end
    end

`ifdef PIPE_SKID_EN
    logic             r_skid_v;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_skid_d;
    logic             w_skid_nxt;

    assign in_ready    = r_in_ready & ~flush;
    assign w_accept    = in_valid & in_ready;
    // The skid entry always drains ahead of fresh input.
    assign w_s0_v      = (r_skid_v & ~flush) | w_accept;
    assign w_s0_d      = r_skid_v ? r_skid_d : in_data;
    assign w_skid_nxt  = ~flush & (r_skid_v ? ~w_adv[0] : (w_accept & ~w_adv[0]));
    assign w_skid_kill = r_skid_v & flush;
    assign w_skid_occ  = r_skid_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b0;
            r_skid_d   <= '0;
        end else begin
            r_skid_v   <= w_skid_nxt;
            r_in_ready <= ~w_skid_nxt;
            if (w_accept && !w_adv[0] && !r_skid_v) begin
                r_skid_d <= in_data;
            end
        end
    end
`else
    assign in_ready    = w_adv[0] & ~flush & ~rst;
    assign w_accept    = in_valid & in_ready;
    assign w_s0_v      = w_accept;
    assign w_s0_d      = in_data;
    assign w_skid_kill = 1'b0;
    assign w_skid_occ  = 1'b0;
`endif

    always_comb begin
        w_src_v    = '0;
        w_src_v[0] = w_s0_v;
        w_src_d[0] = w_s0_d;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_v[i] = w_ev[i-1];
            w_src_d[i] = r_d[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_adv[i]) begin
                    r_v[i] <= w_src_v[i];
                    if (w_src_v[i]) begin
                        r_d[i] <= w_src_d[i];
                    end
                end
            end
        end
    end

    assign w_killed = r_v & (kill_mask | {DEPTH{flush}});

    always_comb begin
        w_kill_pop = '0;
        w_occ      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill_pop = w_kill_pop + c_SUM_W'(w_killed[i]);
            w_occ      = w_occ + c_OCC_W'(r_v[i]);
        end
        w_kill_pop = w_kill_pop + c_SUM_W'(w_skid_kill);
        w_occ      = w_occ + c_OCC_W'(w_skid_occ);
    end

    // Wide sum so any overflow above CNT_W bits is visible before saturating.
    assign w_kill_sum = {6'b0, r_kill_count} + w_kill_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kill_count <= '0;
        end else if (|w_kill_sum[c_SUM_W-1:CNT_W]) begin
            r_kill_count <= '1;
        end else begin
            r_kill_count <= w_kill_sum[CNT_W-1:0];
        end
    end

    assign occupancy  = w_occ;
    assign kill_count = r_kill_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_chain                                        |
// | Description : Directed self-checking bench for pipe_stage_chain.         |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        flush = 1'b0;
    logic [3:0]  kill_mask = '0;
    logic [2:0]  occupancy;
    logic [15:0] kill_count;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [7:0]  b_out_data;
    logic [3:0]  b_kill_mask = '0;
    logic [2:0]  b_occupancy;
    logic [1:0]  b_kill_count;

    int total = 0;
    int bad   = 0;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .kill_mask(kill_mask),
        .occupancy(occupancy), .kill_count(kill_count)
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .flush(1'b0), .kill_mask(b_kill_mask),
        .occupancy(b_occupancy), .kill_count(b_kill_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
        total++; if (kill_count !== 16'd0) begin bad++; $display("FAIL reset_kill_count got=%0d want=0", kill_count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_stream();
        logic       exp_v;
        logic [2:0] exp_occ;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_data  = 32'(16 + c);
            tick();
            exp_v   = (c >= 3) && (c <= 10);
            exp_occ = (c < 8) ? ((c + 1 < 4) ? 3'(c + 1) : 3'd4) : 3'(11 - c);
            total++; if (out_valid !== exp_v) begin bad++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, out_valid, exp_v); end
            if (exp_v) begin
                total++; if (out_data !== 32'(16 + c - 3)) begin bad++; $display("FAIL stream_data c=%0d got=%h want=%h", c, out_data, 32'(16 + c - 3)); end
            end
            total++; if (occupancy !== exp_occ) begin bad++; $display("FAIL stream_occ c=%0d got=%0d want=%0d", c, occupancy, exp_occ); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'(32 + k);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_fill_ready k=%0d got=%b want=1", k, in_ready); end
            tick();
        end
        in_data = 32'h24;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL bp_full_occ got=%0d want=4", occupancy); end
        total++; if (out_data !== 32'h20 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_head got=%b/%h want=1/20", out_valid, out_data); end
        tick();
        total++; if (in_ready !== 1'b0 || out_data !== 32'h20) begin bad++; $display("FAIL bp_hold got=%b/%h want=0/20", in_ready, out_data); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_data !== 32'h21 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_drain k=1 got=%b/%h want=1/21", out_valid, out_data); end
        for (int k = 2; k < 5; k++) begin
            tick();
            total++; if (out_data !== 32'(32 + k) || out_valid !== 1'b1) begin bad++; $display("FAIL bp_drain k=%0d got=%b/%h want=1/%h", k, out_valid, out_data, 32'(32 + k)); end
        end
        tick();
        total++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL bp_empty got=%b/%0d want=0/0", out_valid, occupancy); end
    endtask

    task automatic test_kill();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'(160 + 16 * k);
            tick();
        end
        in_valid  = 1'b0;
        kill_mask = 4'b0100;
        tick();
        kill_mask = 4'b0000;
        total++; if (kill_count !== 16'd1) begin bad++; $display("FAIL kill_count got=%0d want=1", kill_count); end
        total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL kill_occ got=%0d want=3", occupancy); end
        out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== 32'hA0) begin bad++; $display("FAIL kill_out0 got=%b/%h want=1/a0", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hC0) begin bad++; $display("FAIL kill_out1 got=%b/%h want=1/c0", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'hD0) begin bad++; $display("FAIL kill_out2 got=%b/%h want=1/d0", out_valid, out_data); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL kill_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'(48 + k);
            tick();
        end
        in_data   = 32'h99;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occupancy); end
        // One kill already recorded by the kill scenario, plus four flushed beats.
        total++; if (kill_count !== 16'd5) begin bad++; $display("FAIL flush_kill_count got=%0d want=5", kill_count); end
        repeat (4) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_leak got=%b want=0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 32'(64 + k);
            tick();
        end
        total++; if (out_valid !== 1'b1 || out_data !== 32'h40) begin bad++; $display("FAIL ar_pre got=%b/%h want=1/40", out_valid, out_data); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_out_valid got=%b want=0", out_valid); end
        total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL ar_occ got=%0d want=0", occupancy); end
        total++; if (kill_count !== 16'd0) begin bad++; $display("FAIL ar_kill_count got=%0d want=0", kill_count); end
        total++; if (out_data !== 32'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL ar_data_ready got=%h/%b want=0/0", out_data, in_ready); end
        in_valid = 1'b0;
        tick();
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'h50;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_ready_after got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_early got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h50) begin bad++; $display("FAIL ar_latency got=%b/%h want=1/50", out_valid, out_data); end
        tick();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_k;
        b_out_ready = 1'b1;
        b_kill_mask = 4'b0001;
        for (int c = 0; c < 7; c++) begin
            b_in_valid = (c < 5);
            b_in_data  = 8'(c + 1);
            tick();
            exp_k = (c < 3) ? 2'(c) : 2'd3;
            total++; if (b_kill_count !== exp_k) begin bad++; $display("FAIL sat_count c=%0d got=%0d want=%0d", c, b_kill_count, exp_k); end
            total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL sat_out_valid c=%0d got=%b want=0", c, b_out_valid); end
        end
        total++; if (b_occupancy !== 3'd0 || b_out_data !== 8'd0 || b_in_ready !== 1'b1) begin bad++; $display("FAIL sat_idle got=%0d/%h/%b want=0/00/1", b_occupancy, b_out_data, b_in_ready); end
        b_in_valid  = 1'b0;
        b_kill_mask = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_kill();
        test_flush();
        test_async_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
